// File: rtl/std_fu_arbiter.sv
// std_fu_arbiter
//   Shares one functional unit between nreq requesters. One operation is in
//   flight at a time: a winner is accepted in IDLE, its operands are presented
//   to the unit in BUSY until fu_ready, then the captured result is returned
//   to that requester for one cycle in DONE.
//
//   Build option: define STD_FU_ARBITER_ROUND_ROBIN_EN for round-robin
//   arbitration starting after the last grant. Without it the arbiter uses
//   fixed priority, where the lowest valid index wins.
//
// Parameters
//   width : operand/result bit width
//   nreq  : number of requesters (2..8)
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   [nreq]       requester i has an operation pending
//   req_left   in   [nreq*width] left operand of i at [i*width +: width]
//   req_right  in   [nreq*width] right operand of i, same packing
//   req_ready  out  [nreq]       one-hot accept strobe (IDLE only)
//   resp_done  out  [nreq]       one-hot one-cycle result strobe (DONE)
//   resp_out   out  [width]      result, zero unless resp_done is set
//   fu_left    out  [width]      left operand to the unit, zero outside BUSY
//   fu_right   out  [width]      right operand to the unit, zero outside BUSY
//   fu_valid   out               operation valid to the unit (BUSY)
//   fu_ready   in                unit result valid, sampled only in BUSY
//   fu_out     in   [width]      unit result
//   busy       out               high in every state except IDLE
module std_fu_arbiter #(
  parameter int width = 32,
  parameter int nreq  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [nreq-1:0]         req_valid,
  input  logic [nreq*width-1:0]   req_left,
  input  logic [nreq*width-1:0]   req_right,
  output logic [nreq-1:0]         req_ready,
  output logic [nreq-1:0]         resp_done,
  output logic [width-1:0]        resp_out,
  output logic [width-1:0]        fu_left,
  output logic [width-1:0]        fu_right,
  output logic                    fu_valid,
  input  logic                    fu_ready,
  input  logic [width-1:0]        fu_out,
  output logic                    busy
);

  localparam int iw = (nreq > 1) ? $clog2(nreq) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [iw-1:0]     grant_reg;
  logic [width-1:0]  left_reg, right_reg, result_reg;
  logic [iw-1:0]     win;
  logic              any_valid;
  logic              accept;

  // Unpack the flat operand buses into per-requester slices.
  logic [width-1:0]  left_arr  [nreq];
  logic [width-1:0]  right_arr [nreq];

  generate
    for (genvar gi = 0; gi < nreq; gi++) begin : g_unpack
      assign left_arr[gi]  = req_left[gi*width +: width];
      assign right_arr[gi] = req_right[gi*width +: width];
    end
  endgenerate

  assign any_valid = |req_valid;
  assign accept    = (state_reg == IDLE) && any_valid;

`ifdef STD_FU_ARBITER_ROUND_ROBIN_EN
  logic [iw-1:0] last_reg;
  logic [iw-1:0] idx;
  logic          found;

  // Search upward from the slot after the previous winner, wrapping.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= nreq; k++) begin
      idx = iw'((int'(last_reg) + k) % nreq);
      if (!found && req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= iw'(nreq - 1);
    end else if (accept) begin
      last_reg <= win;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest valid index.
  always_comb begin
    win = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      if (req_valid[i]) win = iw'(i);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic. BUSY has no timeout; fu_ready matters only there.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = BUSY;
      BUSY:    if (fu_ready)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: operands latched at accept, result at completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_reg  <= '0;
      left_reg   <= '0;
      right_reg  <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        grant_reg <= win;
        left_reg  <= left_arr[win];
        right_reg <= right_arr[win];
      end
      if ((state_reg == BUSY) && fu_ready) begin
        result_reg <= fu_out;
      end
    end
  end

  // Outputs. req_ready is also gated by reset so that no accept is
  // advertised while reset is held, even though the state reads IDLE.
  always_comb begin
    req_ready = '0;
    resp_done = '0;
    resp_out  = '0;
    fu_left   = '0;
    fu_right  = '0;
    fu_valid  = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (any_valid && reset) req_ready[win] = 1'b1;
      end
      BUSY: begin
        fu_valid = 1'b1;
        fu_left  = left_reg;
        fu_right = right_reg;
      end
      DONE: begin
        resp_done[grant_reg] = 1'b1;
        resp_out             = result_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_std_fu_arbiter.sv
module tb_std_fu_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_left;
  logic [N*W-1:0]   req_right;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     resp_done;
  logic [W-1:0]     resp_out;
  logic [W-1:0]     fu_left;
  logic [W-1:0]     fu_right;
  logic             fu_valid;
  logic             fu_ready;
  logic [W-1:0]     fu_out;
  logic             busy;

  int checks = 0;
  int errors = 0;

  std_fu_arbiter #(.width(W), .nreq(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_left(req_left), .req_right(req_right),
    .req_ready(req_ready), .resp_done(resp_done), .resp_out(resp_out),
    .fu_left(fu_left), .fu_right(fu_right), .fu_valid(fu_valid),
    .fu_ready(fu_ready), .fu_out(fu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] valid;
    int           exp_fp;   // winner under fixed priority
    int           exp_rr;   // winner under round robin, given run order
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] opl(input int v, input int i);
    return {8'(v), 8'(i), 16'h1111};
  endfunction

  function automatic logic [W-1:0] opr(input int v, input int i);
    return {8'(v), 8'(i), 16'h2222};
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) begin
      req_left[i*W +: W]  = opl(v, i);
      req_right[i*W +: W] = opr(v, i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    fu_ready  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One full transaction with fu_ready held high: accept, BUSY, DONE, IDLE.
  task automatic run_txn(input string tag, input logic [N-1:0] valid, input int g,
                         input logic [W-1:0] el, input logic [W-1:0] er,
                         input logic [W-1:0] res);
    @(negedge clk);
    req_valid = valid;
    fu_ready  = 1'b1;
    fu_out    = res;
    #1;
    chk({tag, ".c0.req_ready"}, 64'(req_ready), 64'(oh(g)));
    chk({tag, ".c0.busy"}, 64'(busy), 64'd0);
    chk({tag, ".c0.fu_valid"}, 64'(fu_valid), 64'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({tag, ".c1.fu_valid"}, 64'(fu_valid), 64'd1);
    chk({tag, ".c1.busy"}, 64'(busy), 64'd1);
    chk({tag, ".c1.req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, ".c1.fu_left"}, 64'(fu_left), 64'(el));
    chk({tag, ".c1.fu_right"}, 64'(fu_right), 64'(er));
    chk({tag, ".c1.resp_done"}, 64'(resp_done), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".c2.resp_done"}, 64'(resp_done), 64'(oh(g)));
    chk({tag, ".c2.resp_out"}, 64'(resp_out), 64'(res));
    chk({tag, ".c2.fu_valid"}, 64'(fu_valid), 64'd0);
    chk({tag, ".c2.fu_left"}, 64'(fu_left), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".c3.resp_done"}, 64'(resp_done), 64'd0);
    chk({tag, ".c3.busy"}, 64'(busy), 64'd0);
    chk({tag, ".c3.resp_out"}, 64'(resp_out), 64'd0);
    $display("txn %s valid=%b grant=%0d result=%0h checks=%0d errors=%0d",
             tag, valid, g, res, checks, errors);
  endtask

  int order_fp [5] = '{0, 0, 0, 0, 0};
  int order_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    int g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_done;

    // Run in this order directly after reset (last starts at 3).
    vecs[0] = '{4'b0001, 0, 0};
    vecs[1] = '{4'b0110, 1, 1};
    vecs[2] = '{4'b1010, 1, 3};
    vecs[3] = '{4'b1111, 0, 0};
    vecs[4] = '{4'b1000, 3, 3};
    vecs[5] = '{4'b0101, 0, 0};
    vecs[6] = '{4'b0011, 0, 1};
    vecs[7] = '{4'b0011, 0, 0};

    reset     = 1'b0;
    req_valid = '0;
    req_left  = '0;
    req_right = '0;
    fu_ready  = 1'b0;
    fu_out    = '0;

    // Reset state, with requests and fu_ready pushing on the inputs.
    @(negedge clk);
    req_valid = 4'b1111;
    fu_ready  = 1'b1;
    fu_out    = 32'hdead_beef;
    fill(1);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.fu_valid", 64'(fu_valid), 64'd0);
    chk("rst.resp_done", 64'(resp_done), 64'd0);
    chk("rst.resp_out", 64'(resp_out), 64'd0);
    chk("rst.fu_left", 64'(fu_left), 64'd0);
    @(negedge clk);
    #1;
    chk("rst.busy_hold", 64'(busy), 64'd0);
    $display("txn reset_state checks=%0d errors=%0d", checks, errors);
    req_valid = '0;
    fu_ready  = 1'b0;
    reset     = 1'b1;

    // Single request: 3 + 4 -> 7 on requester 0.
    req_left  = '0;
    req_right = '0;
    req_left[0 +: W]  = 32'd3;
    req_right[0 +: W] = 32'd4;
    run_txn("single", 4'b0001, 0, 32'd3, 32'd4, 32'd7);

    // Table of single transactions.
    do_reset();
    for (int v = 0; v < 8; v++) begin
`ifdef STD_FU_ARBITER_ROUND_ROBIN_EN
      g = vecs[v].exp_rr;
`else
      g = vecs[v].exp_fp;
`endif
      fill(v + 1);
      run_txn($sformatf("vec%0d", v), vecs[v].valid, g,
              opl(v + 1, g), opr(v + 1, g), 32'(v * 7 + 3));
    end

    // All requesters valid continuously: an accept every 3 cycles.
    do_reset();
    fill(9);
    fu_ready = 1'b1;
    fu_out   = 32'h55;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 4'b1111;
      #1;
`ifdef STD_FU_ARBITER_ROUND_ROBIN_EN
      g = order_rr[c / 3];
`else
      g = order_fp[c / 3];
`endif
      exp_rdy  = (c % 3 == 0) ? oh(g) : '0;
      exp_done = (c % 3 == 2) ? oh(g) : '0;
      chk($sformatf("stream.c%0d.req_ready", c), 64'(req_ready), 64'(exp_rdy));
      chk($sformatf("stream.c%0d.resp_done", c), 64'(resp_done), 64'(exp_done));
    end
    $display("txn stream grants checked checks=%0d errors=%0d", checks, errors);
    @(negedge clk);
    req_valid = '0;

    // Stall: fu_ready low for 10 BUSY cycles.
    fill(5);
    @(negedge clk);
    req_valid = 4'b0010;
    fu_ready  = 1'b0;
    fu_out    = 32'h1234_5678;
    #1;
    chk("stall.req_ready", 64'(req_ready), 64'(oh(1)));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      chk($sformatf("stall.k%0d.fu_valid", k), 64'(fu_valid), 64'd1);
      chk($sformatf("stall.k%0d.fu_left", k), 64'(fu_left), 64'(opl(5, 1)));
      chk($sformatf("stall.k%0d.fu_right", k), 64'(fu_right), 64'(opr(5, 1)));
      chk($sformatf("stall.k%0d.busy", k), 64'(busy), 64'd1);
      chk($sformatf("stall.k%0d.resp_done", k), 64'(resp_done), 64'd0);
    end
    @(negedge clk);
    fu_ready = 1'b1;
    #1;
    chk("stall.rise.resp_done", 64'(resp_done), 64'd0);
    chk("stall.rise.fu_valid", 64'(fu_valid), 64'd1);
    @(negedge clk);
    fu_ready = 1'b0;
    #1;
    chk("stall.done.resp_done", 64'(resp_done), 64'(oh(1)));
    chk("stall.done.resp_out", 64'(resp_out), 64'h1234_5678);
    @(negedge clk);
    #1;
    chk("stall.idle.busy", 64'(busy), 64'd0);
    $display("txn stall grant=1 checks=%0d errors=%0d", checks, errors);

    // Reset in BUSY for requester 2 aborts the transaction.
    fill(6);
    @(negedge clk);
    req_valid = 4'b0100;
    fu_ready  = 1'b0;
    fu_out    = 32'h99;
    #1;
    chk("abort.req_ready", 64'(req_ready), 64'(oh(2)));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("abort.busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("abort.fu_valid", 64'(fu_valid), 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.req_ready", 64'(req_ready), 64'd0);
    chk("abort.resp_done", 64'(resp_done), 64'd0);
    chk("abort.fu_left", 64'(fu_left), 64'd0);
    chk("abort.fu_right", 64'(fu_right), 64'd0);
    chk("abort.resp_out", 64'(resp_out), 64'd0);
    fu_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("abort.hold.resp_done", 64'(resp_done), 64'd0);
    reset = 1'b1;
    #1;
    chk("abort.regrant", 64'(req_ready), 64'(oh(0)));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("abort.regrant.fu_left", 64'(fu_left), 64'(opl(6, 0)));
    @(negedge clk);
    #1;
    chk("abort.regrant.resp_done", 64'(resp_done), 64'(oh(0)));
    chk("abort.regrant.resp_out", 64'(resp_out), 64'h99);
    $display("txn abort_then_grant0 checks=%0d errors=%0d", checks, errors);

    // fu_ready pulsed in IDLE with no requests: nothing happens.
    @(negedge clk);
    fu_ready = 1'b1;
    #1;
    chk("idlepulse.busy0", 64'(busy), 64'd0);
    @(negedge clk);
    fu_ready = 1'b0;
    #1;
    chk("idlepulse.busy1", 64'(busy), 64'd0);
    chk("idlepulse.resp_done", 64'(resp_done), 64'd0);
    chk("idlepulse.fu_valid", 64'(fu_valid), 64'd0);
    $display("txn idle_fu_ready_pulse checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
